// File: rtl/instr_fetch_if.sv
// Bus bundle between instr_fetch and its neighbours: the program-memory read
// port and the instruction hand-off to instruction_decode.
//
// Handshake rules:
//   Memory read: mem_req/mem_addr are held stable until the cycle in which
//   mem_ack is high. That cycle completes the read, and mem_rdata is valid only
//   in that cycle.
//   Instruction hand-off: ir_valid/ir/ir_tgt are held stable until the cycle in
//   which ir_ready is high. That cycle is the accept cycle. ir_ready has no
//   effect while ir_valid is low.
interface instr_fetch_if #(
  parameter int AW = 8
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [7:0]    mem_rdata;
  logic [7:0]    ir;
  logic [AW-1:0] ir_tgt;
  logic          ir_valid;
  logic          ir_ready;

  // Fetch-stage side.
  modport master (
    output mem_req, mem_addr, ir, ir_tgt, ir_valid,
    input  mem_ack, mem_rdata, ir_ready
  );

  // Memory / decode side.
  modport slave (
    input  mem_req, mem_addr, ir, ir_tgt, ir_valid,
    output mem_ack, mem_rdata, ir_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage of the simple CPU.
// It walks the PC through program memory and latches each opcode into IR.
// For the two-byte jumps jmp/jz/jc it also fetches the target byte.
// It hands each instruction to decode, then redirects the PC on the accept
// cycle using the ALU flags. Halt (8'h80) freezes fetch until reset.
// Optional feature: define IF_STALL_CNT_EN to add the stall_cnt output.
// stall_cnt is a saturating count of cycles spent waiting on memory or decode.
module instr_fetch #(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  instr_fetch_if.master bus,
  input  logic          zf,
  input  logic          cf,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic [2:0]    dbg_state
`ifdef IF_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam logic [7:0] OP_JMP  = 8'h30;
  localparam logic [7:0] OP_JZ   = 8'h31;
  localparam logic [7:0] OP_JC   = 8'h32;
  localparam logic [7:0] OP_HALT = 8'h80;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    TGT   = 3'd2,
    ISSUE = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] pc_nxt;
  logic [7:0]    ir_q, ir_nxt;
  logic [AW-1:0] tgt_q, tgt_nxt;
  logic          take_jump;

  // Only these three opcodes carry a target byte.
  // 0x33..0x3F pass through as ordinary single-byte ops.
  function automatic logic is_two_byte(input logic [7:0] op);
    return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
  endfunction

  // State, PC and instruction registers. Reset abandons any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      ir_q  <= 8'h00;
      tgt_q <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir_q  <= ir_nxt;
      tgt_q <= tgt_nxt;
    end
  end

  // Next-state logic.
  // en is looked at only in IDLE and when leaving ISSUE, so an instruction
  // already started always runs to completion.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir_q;
    tgt_nxt   = tgt_q;
    take_jump = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_nxt = FETCH;
      end
      FETCH: begin
        if (bus.mem_ack) begin
          ir_nxt    = bus.mem_rdata;
          pc_nxt    = pc + AW'(1);
          state_nxt = is_two_byte(bus.mem_rdata) ? TGT : ISSUE;
        end
      end
      TGT: begin
        if (bus.mem_ack) begin
          tgt_nxt   = AW'(bus.mem_rdata);
          pc_nxt    = pc + AW'(1);
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.ir_ready) begin
          take_jump = (ir_q == OP_JMP) ||
                      ((ir_q == OP_JZ) && zf) ||
                      ((ir_q == OP_JC) && cf);
          if (take_jump) pc_nxt = tgt_q;
          if (ir_q == OP_HALT) state_nxt = HALT;
          else                 state_nxt = en ? FETCH : IDLE;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // All outputs are decoded from registered state, so they are glitch-free.
  assign bus.mem_req  = (state == FETCH) || (state == TGT);
  assign bus.mem_addr = pc;
  assign bus.ir       = ir_q;
  assign bus.ir_tgt   = tgt_q;
  assign bus.ir_valid = (state == ISSUE);
  assign halted       = (state == HALT);
  assign dbg_state    = state;

`ifdef IF_STALL_CNT_EN
  logic stall;
  assign stall = (((state == FETCH) || (state == TGT)) && !bus.mem_ack) ||
                 ((state == ISSUE) && !bus.ir_ready);

  // Saturating count of cycles lost to memory or decode back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             stall_cnt <= 16'h0000;
    else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch.
// Random memory latency, decode back-pressure, enable and flag values are
// applied. Each issued instruction is compared with a program-level model of
// the PC. A second instance checks RESET_PC = 0xFF.
module tb_instr_fetch;

  logic       clk;
  logic       rst_n, en, zf, cf;
  logic [7:0] pc;
  logic       halted;
  logic [2:0] dbg_state;
  logic       rst2_n, en2;
  logic [7:0] pc2;
  logic       halted2;
  logic [2:0] dbg2;
`ifdef IF_STALL_CNT_EN
  logic [15:0] stall_cnt, stall2;
`endif

  instr_fetch_if #(.AW(8)) bus ();
  instr_fetch_if #(.AW(8)) bus2 ();

  instr_fetch #(.AW(8), .RESET_PC(8'h00)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bus       (bus),
    .zf        (zf),
    .cf        (cf),
    .pc        (pc),
    .halted    (halted),
    .dbg_state (dbg_state)
`ifdef IF_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  instr_fetch #(.AW(8), .RESET_PC(8'hFF)) u_dut_ff (
    .clk       (clk),
    .rst_n     (rst2_n),
    .en        (en2),
    .bus       (bus2),
    .zf        (zf),
    .cf        (cf),
    .pc        (pc2),
    .halted    (halted2),
    .dbg_state (dbg2)
`ifdef IF_STALL_CNT_EN
    ,
    .stall_cnt (stall2)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0] mem [256];
  logic [7:0] exp_q[$];   // expected memory read addresses, oldest first
  logic [7:0] m_pc;       // model: address of the next instruction
  int         exp_stall;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit is_jump2(input logic [7:0] op);
    return op inside {8'h30, 8'h31, 8'h32};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 5) == 0) mem[i] = 8'h30 + 8'($urandom_range(0, 2));
      else begin
        mem[i] = 8'($urandom);
        if (mem[i] == 8'h80) mem[i] = 8'h81;
      end
    end
  endtask

  // Expected reads for the instruction at m_pc: the opcode byte, then the
  // target byte for a two-byte jump.
  task automatic queue_reads();
    logic [7:0] a1;
    a1 = m_pc + 8'd1;
    exp_q.push_back(m_pc);
    if (is_jump2(mem[m_pc])) exp_q.push_back(a1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; zf = 1'b0; cf = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00; bus.ir_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pc = 8'h00;
    exp_stall = 0;
    exp_q.delete();
  endtask

  // Run until n_instr instructions are accepted or a halt is seen.
  // rnd randomizes en, memory latency and ir_ready.
  // zf_mode/cf_mode: 0 = hold 0, 1 = hold 1, 2 = random.
  task automatic run_prog(input int n_instr, input bit rnd, input int zf_mode, input int cf_mode);
    int         issued, cycles, bad;
    bit         prev_acc, halt_seen, done;
    logic [7:0] op, p1, tgt, nxt;
    issued = 0; cycles = 0; prev_acc = 0; halt_seen = 0; done = 0;
    queue_reads();
    while (!done && cycles < 4000) begin
      @(negedge clk);
      cycles++;
      if (prev_acc) begin
        check("no_b2b_valid", bus.ir_valid, 1'b0);
        check("pc_after_issue", pc, m_pc);
        prev_acc = 0;
        if (halt_seen) begin
          check("halted", halted, 1'b1);
          bad = 0;
          for (int i = 0; i < 20; i++) begin
            en = 1'b1; bus.mem_ack = 1'b0; bus.ir_ready = 1'b1;
            @(negedge clk);
            if (bus.mem_req || bus.ir_valid || !halted) bad++;
          end
          check("halt_quiet", bad, 0);
          done = 1;
        end else if (issued >= n_instr) begin
          done = 1;
        end
      end
      if (!done) begin
        en = rnd ? ($urandom_range(0, 9) != 0) : 1'b1;
        zf = (zf_mode == 2) ? 1'($urandom_range(0, 1)) : zf_mode[0];
        cf = (cf_mode == 2) ? 1'($urandom_range(0, 1)) : cf_mode[0];
        bus.mem_ack   = bus.mem_req && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
        bus.mem_rdata = mem[bus.mem_addr];
        bus.ir_ready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        if ((bus.mem_req && !bus.mem_ack) || (bus.ir_valid && !bus.ir_ready)) exp_stall++;
        if (bus.mem_ack) begin
          if (exp_q.size() == 0) check("unexpected_read", 1, 0);
          else check("mem_addr", bus.mem_addr, exp_q.pop_front());
        end
        if (bus.ir_valid && bus.ir_ready) begin
          op  = mem[m_pc];
          p1  = m_pc + 8'd1;
          tgt = mem[p1];
          check("ir", bus.ir, op);
          if (is_jump2(op)) check("ir_tgt", bus.ir_tgt, tgt);
          nxt = m_pc + (is_jump2(op) ? 8'd2 : 8'd1);
          if (op == 8'h30 || (op == 8'h31 && zf) || (op == 8'h32 && cf)) nxt = tgt;
          m_pc = nxt;
          issued++;
          prev_acc = 1;
          if (op == 8'h80) halt_seen = 1;
          else if (issued < n_instr) queue_reads();
        end
      end
    end
    if (!done) check("run_timeout", issued, n_instr);
`ifdef IF_STALL_CNT_EN
    check("stall_cnt", stall_cnt, exp_stall);
`endif
  endtask

  // Decode holds off for 4 cycles. The instruction must stay put, and no
  // fetch may start while it waits.
  task automatic ready_hold_test();
    bit seen;
    clear_mem();
    mem[0] = 8'h55;
    do_reset();
    en = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      bus.mem_ack = bus.mem_req;
      bus.mem_rdata = mem[bus.mem_addr];
      if (bus.ir_valid) seen = 1;
    end
    if (!seen) check("hold_timeout", 0, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("hold_valid", bus.ir_valid, 1'b1);
      check("hold_ir", bus.ir, 8'h55);
      check("hold_no_req", bus.mem_req, 1'b0);
    end
    @(negedge clk);
    bus.ir_ready = 1'b1;
    bus.mem_ack  = 1'b0;
    @(negedge clk);
    bus.ir_ready = 1'b0;
    check("hold_released", bus.ir_valid, 1'b0);
    check("hold_pc", pc, 8'h01);
`ifdef IF_STALL_CNT_EN
    check("hold_stall_cnt", stall_cnt, 16'd4);
`endif
  endtask

  // A reset in the middle of FETCH abandons the read. An ack that arrives
  // late must not load IR.
  task automatic reset_mid_fetch_test();
    bit seen;
    clear_mem();
    mem[0] = 8'h77;
    do_reset();
    en = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (bus.mem_req) seen = 1;
    end
    check("mid_fetch_req", bus.mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_state", dbg_state, 3'd0);
    check("mid_rst_req", bus.mem_req, 1'b0);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'h77;
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("late_ack_state", dbg_state, 3'd0);
    check("late_ack_ir", bus.ir, 8'h00);
    bus.mem_ack = 1'b0;
  endtask

  // RESET_PC = 0xFF: the op at 0xFF is followed by a fetch from 0x00.
  task automatic reset_pc_ff_test();
    bit got;
    int n_ack;
    clear_mem();
    mem[8'hFF] = 8'h12;
    mem[8'h00] = 8'h34;
    rst2_n = 1'b0; en2 = 1'b0;
    bus2.mem_ack = 1'b0; bus2.mem_rdata = 8'h00; bus2.ir_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("ff_reset_pc", pc2, 8'hFF);
    rst2_n = 1'b1;
    en2 = 1'b1;
    got = 0; n_ack = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      bus2.mem_ack = bus2.mem_req;
      bus2.mem_rdata = mem[bus2.mem_addr];
      bus2.ir_ready = 1'b1;
      if (bus2.mem_ack) begin
        if (n_ack == 0) check("ff_first_addr", bus2.mem_addr, 8'hFF);
        n_ack++;
      end
      if (bus2.ir_valid) begin
        check("ff_ir", bus2.ir, 8'h12);
        got = 1;
      end
    end
    if (!got) check("ff_timeout", 0, 1);
    bus2.mem_ack = 1'b0;
    @(negedge clk);
    check("ff_pc_wrap", pc2, 8'h00);
    check("ff_next_req", bus2.mem_req, 1'b1);
    check("ff_next_addr", bus2.mem_addr, 8'h00);
    @(negedge clk);
    #2 rst2_n = 1'b0;
    #1;
    check("ff_rst_state", dbg2, 3'd0);
    check("ff_rst_req", bus2.mem_req, 1'b0);
    check("ff_rst_pc", pc2, 8'hFF);
    en2 = 1'b0;
    @(negedge clk);
    rst2_n = 1'b1;
  endtask

  // ---------------- global time limit ----------------
  initial begin
    #3000000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1, "global timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst2_n = 1'b0; en2 = 1'b0;
    bus2.mem_ack = 1'b0; bus2.mem_rdata = 8'h00; bus2.ir_ready = 1'b0;
    clear_mem();
    do_reset();
    check("rst_pc", pc, 8'h00);
    check("rst_ir", bus.ir, 8'h00);
    check("rst_ir_tgt", bus.ir_tgt, 8'h00);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_ir_valid", bus.ir_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_state", dbg_state, 3'd0);

    // Straight-line code: three single-byte ops, ending with pc at 3.
    clear_mem();
    mem[0] = 8'h90; mem[1] = 8'h60; mem[2] = 8'h70;
    do_reset();
    run_prog(3, 1'b0, 0, 0);

    // Unconditional jump; the next read comes from the target.
    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'h05; mem[5] = 8'h44;
    do_reset();
    run_prog(2, 1'b0, 0, 0);

    // jz at 4 with target 0x10: falls through when zf=0, taken when zf=1.
    clear_mem();
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
    mem[4] = 8'h31; mem[5] = 8'h10; mem[6] = 8'h06; mem[8'h10] = 8'h66;
    do_reset();
    run_prog(6, 1'b0, 0, 0);
    do_reset();
    run_prog(6, 1'b0, 1, 0);

    // jc with cf held low, then high; single-byte 0x33 passes straight through.
    clear_mem();
    mem[0] = 8'h33; mem[1] = 8'h32; mem[2] = 8'h20; mem[3] = 8'h0A; mem[8'h20] = 8'h0B;
    do_reset();
    run_prog(3, 1'b0, 0, 0);
    do_reset();
    run_prog(3, 1'b0, 0, 1);

    // Two-byte jump at 0xFE..0xFF, and a target byte that wraps to address 0.
    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'hFE;
    mem[8'hFE] = 8'h31; mem[8'hFF] = 8'h40;
    mem[8'h40] = 8'h30; mem[8'h41] = 8'hFF;
    mem[8'hFF] = 8'h40;
    do_reset();
    run_prog(4, 1'b1, 1, 2);

    ready_hold_test();

    // Halt after a jump, then reset releases it.
    clear_mem();
    mem[0] = 8'h11; mem[1] = 8'h30; mem[2] = 8'h40; mem[8'h40] = 8'h80;
    do_reset();
    run_prog(10, 1'b1, 2, 2);
    do_reset();
    check("post_halt_pc", pc, 8'h00);
    check("post_halt_halted", halted, 1'b0);

    reset_mid_fetch_test();

    // Random programs with random latency and back-pressure.
    for (int r = 0; r < 4; r++) begin
      fill_random();
      do_reset();
      run_prog(60, 1'b1, 2, 2);
    end

    reset_pc_ff_test();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
